// File: rtl/snn_tick_scheduler_if.sv
// snn_tick_scheduler_if: control/status bundle between the host-side tick
// control and the SNN timestep scheduler.
// Optional spike counter signal guarded by SNN_TICK_SCHED_SPIKE_CNT_EN.
interface snn_tick_scheduler_if #(
  parameter int PERIOD_W = 16,
  parameter int STEP_W   = 16
);
  logic                start;
  logic                abort;
  logic [STEP_W-1:0]   num_steps;
  logic [PERIOD_W-1:0] tick_period;
  logic                input_buffer_empty;
  logic                token_controller_error;
  logic                scheduler_error;
  logic                packet_out_valid;
  logic                tick;
  logic                busy;
  logic                done;
  logic                error;
  logic                overrun;
  logic [STEP_W-1:0]   step_count;
`ifdef SNN_TICK_SCHED_SPIKE_CNT_EN
  logic [15:0]         spike_count;
`endif

  // Host / grid side: drives control and core flags, observes status.
  modport master (
    output start, abort, num_steps, tick_period, input_buffer_empty,
           token_controller_error, scheduler_error, packet_out_valid,
`ifdef SNN_TICK_SCHED_SPIKE_CNT_EN
    input  spike_count,
`endif
    input  tick, busy, done, error, overrun, step_count
  );

  // Scheduler side.
  modport slave (
    input  start, abort, num_steps, tick_period, input_buffer_empty,
           token_controller_error, scheduler_error, packet_out_valid,
`ifdef SNN_TICK_SCHED_SPIKE_CNT_EN
    output spike_count,
`endif
    output tick, busy, done, error, overrun, step_count
  );
endinterface

// File: rtl/snn_tick_scheduler.sv
// snn_tick_scheduler: issues the grid timestep pulse at a programmable
// minimum spacing, holding ticks back while the packet buffer is non-empty,
// for a programmed number of steps. Core error flags park it in FAULT until
// an abort. Define SNN_TICK_SCHED_SPIKE_CNT_EN to add the per-step output
// spike counter.
module snn_tick_scheduler #(
  parameter int PERIOD_W = 16,
  parameter int STEP_W   = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  snn_tick_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_TICK  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [STEP_W-1:0]   r_num_steps;
  logic [STEP_W-1:0]   r_step_count;
  logic [PERIOD_W-1:0] r_period_m1;
  logic [PERIOD_W-1:0] r_timer;
  logic [PERIOD_W-1:0] w_period_m1;
  logic                r_tick;
  logic                r_busy;
  logic                r_done;
  logic                r_error;
  logic                r_overrun;
  logic                w_core_err;
  logic                w_timer_hit;
  logic                w_final;
  logic                w_tick_d;
  logic                w_busy_d;
  logic                w_done_d;

  assign w_core_err  = bus.token_controller_error | bus.scheduler_error;
  assign w_timer_hit = (r_timer == r_period_m1);
  // Step count is already incremented while in TICK, so this is the final tick.
  assign w_final     = (r_step_count == r_num_steps);
  // Periods below 2 are clamped to 2; we store period-1 as the timer terminal.
  assign w_period_m1 = (bus.tick_period < PERIOD_W'(2)) ? PERIOD_W'(1)
                                                         : (bus.tick_period - PERIOD_W'(1));

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; abort overrides every other condition.
  always_comb begin
    w_next_state = r_state;
    if (bus.abort) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start && (bus.num_steps != {STEP_W{1'b0}})) w_next_state = ST_WAIT;
          else                                                w_next_state = ST_IDLE;
        end
        ST_WAIT: begin
          if (w_core_err)                                  w_next_state = ST_FAULT;
          else if (w_timer_hit && bus.input_buffer_empty)  w_next_state = ST_TICK;
          else                                             w_next_state = ST_WAIT;
        end
        ST_TICK: begin
          if (w_core_err)   w_next_state = ST_FAULT;
          else if (w_final) w_next_state = ST_IDLE;
          else              w_next_state = ST_WAIT;
        end
        ST_FAULT: w_next_state = ST_FAULT;
        default:  w_next_state = ST_IDLE;
      endcase
    end
  end

  // Output decode, computed one cycle early so the outputs leave from flops.
  always_comb begin
    w_tick_d = (w_next_state == ST_TICK);
    w_busy_d = (w_next_state == ST_WAIT) || (w_next_state == ST_TICK);
    if (bus.abort) begin
      w_done_d = 1'b0;
    end else if (r_state == ST_IDLE) begin
      w_done_d = bus.start && (bus.num_steps == {STEP_W{1'b0}});
    end else if (r_state == ST_TICK) begin
      w_done_d = !w_core_err && w_final;
    end else begin
      w_done_d = 1'b0;
    end
  end

  // Registered pulse/level outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tick <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_tick <= w_tick_d;
      r_busy <= w_busy_d;
      r_done <= w_done_d;
    end
  end

  // Run configuration, cycle timer, step counter and sticky flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_num_steps  <= {STEP_W{1'b0}};
      r_step_count <= {STEP_W{1'b0}};
      r_period_m1  <= PERIOD_W'(1);
      r_timer      <= {PERIOD_W{1'b0}};
      r_error      <= 1'b0;
      r_overrun    <= 1'b0;
    end else if (!bus.abort) begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_num_steps  <= bus.num_steps;
            r_period_m1  <= w_period_m1;
            r_step_count <= {STEP_W{1'b0}};
            r_timer      <= {PERIOD_W{1'b0}};
            r_error      <= 1'b0;
            r_overrun    <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (w_core_err) begin
            r_error <= 1'b1;
          end else if (w_timer_hit) begin
            if (bus.input_buffer_empty) begin
              r_timer      <= {PERIOD_W{1'b0}};
              r_step_count <= r_step_count + STEP_W'(1);
            end else begin
              r_overrun <= 1'b1;
            end
          end else begin
            r_timer <= r_timer + PERIOD_W'(1);
          end
        end
        ST_TICK: begin
          r_timer <= r_timer + PERIOD_W'(1);
          if (w_core_err) r_error <= 1'b1;
        end
        ST_FAULT: begin
          r_error <= 1'b1;
        end
        default: begin
          r_timer <= {PERIOD_W{1'b0}};
        end
      endcase
    end
  end

  assign bus.tick       = r_tick;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.error      = r_error;
  assign bus.overrun    = r_overrun;
  assign bus.step_count = r_step_count;

`ifdef SNN_TICK_SCHED_SPIKE_CNT_EN
  logic [15:0] r_spk_acc;
  logic [15:0] r_spike_count;
  logic [15:0] w_spk_next;

  // Saturating increment used by the spike accumulator.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
    if (en && (v != 16'hFFFF)) return v + 16'd1;
    else                       return v;
  endfunction

  assign w_spk_next = sat_inc16(r_spk_acc, bus.packet_out_valid);

  // Count output spikes; on each tick publish the step total and restart.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_spk_acc     <= 16'd0;
      r_spike_count <= 16'd0;
    end else if (r_tick) begin
      r_spike_count <= w_spk_next;
      r_spk_acc     <= 16'd0;
    end else begin
      r_spk_acc     <= w_spk_next;
    end
  end

  assign bus.spike_count = r_spike_count;
`else
  logic w_unused_pov;
  assign w_unused_pov = bus.packet_out_valid;
`endif

endmodule

// File: tb/tb_snn_tick_scheduler.sv
// tb_snn_tick_scheduler: directed scenarios plus randomized traffic, checked
// every cycle against an event-level reference model of the tick schedule.
module tb_snn_tick_scheduler;
  localparam int PW = 16;
  localparam int SW = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  snn_tick_scheduler_if #(.PERIOD_W(PW), .STEP_W(SW)) u_if ();

  snn_tick_scheduler #(.PERIOD_W(PW), .STEP_W(SW)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (u_if.slave)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Inputs applied in the next stepped cycle.
  logic          d_start = 1'b0, d_abort = 1'b0, d_empty = 1'b1;
  logic          d_tce = 1'b0, d_se = 1'b0, d_pov = 1'b0;
  logic [SW-1:0] d_num = '0;
  logic [PW-1:0] d_per = '0;

  // Reference model: run/fault flags, next eligible sample cycle, counts.
  bit m_run = 0, m_fault = 0, m_err = 0, m_ovr = 0, m_tick = 0, m_done = 0;
  int m_steps = 0, m_target = 0, m_period = 2, m_ready = 0;
  int m_acc = 0, m_spk = 0;

  int tick_log[$];
  int done_log[$];
  int t0;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int q_at(input int q[$], input int i);
    if (i < q.size()) return q[i];
    else return -1;
  endfunction

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  // Advance the model over one cycle whose inputs are the d_* values.
  function automatic void model_update();
    bit n_tick = 0;
    bit n_done = 0;
    if (d_abort) begin
      m_run = 0;
      m_fault = 0;
    end else if (!m_fault) begin
      if (!m_run) begin
        if (d_start) begin
          m_err = 0; m_ovr = 0; m_steps = 0; m_target = int'(d_num);
          m_period = (d_per < 2) ? 2 : int'(d_per);
          if (d_num == 0) n_done = 1;
          else begin m_run = 1; m_ready = cyc + m_period; end
        end
      end else if (d_tce || d_se) begin
        m_err = 1; m_run = 0; m_fault = 1;
      end else if (m_tick && m_steps == m_target) begin
        m_run = 0; n_done = 1;
      end else if (!m_tick && cyc >= m_ready) begin
        if (d_empty) begin
          n_tick = 1; m_steps = m_steps + 1; m_ready = cyc + m_period;
        end else begin
          m_ovr = 1;
        end
      end
    end
    if (m_tick) begin
      m_spk = sat16(m_acc + int'(d_pov));
      m_acc = 0;
    end else begin
      m_acc = sat16(m_acc + int'(d_pov));
    end
    m_tick = n_tick;
    m_done = n_done;
  endfunction

  // Called at a negedge: check this cycle, drive inputs, step model, wait.
  task automatic step_cycle();
    chk_eq("tick", u_if.tick, m_tick);
    chk_eq("done", u_if.done, m_done);
    chk_eq("busy", u_if.busy, m_run);
    chk_eq("error", u_if.error, m_err);
    chk_eq("overrun", u_if.overrun, m_ovr);
    chk_eq("step_count", u_if.step_count, m_steps[15:0]);
`ifdef SNN_TICK_SCHED_SPIKE_CNT_EN
    chk_eq("spike_count", u_if.spike_count, m_spk);
`endif
    if (u_if.tick) tick_log.push_back(cyc);
    if (u_if.done) done_log.push_back(cyc);
    u_if.start = d_start; u_if.abort = d_abort; u_if.num_steps = d_num;
    u_if.tick_period = d_per; u_if.input_buffer_empty = d_empty;
    u_if.token_controller_error = d_tce; u_if.scheduler_error = d_se;
    u_if.packet_out_valid = d_pov;
    model_update();
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step_cycle();
  endtask

  task automatic start_run(input int num, input int per);
    tick_log.delete();
    done_log.delete();
    d_num = SW'(num); d_per = PW'(per); d_start = 1'b1;
    t0 = cyc;
    step_cycle();
    d_start = 1'b0;
  endtask

  initial begin
    u_if.start = 1'b0; u_if.abort = 1'b0; u_if.num_steps = '0; u_if.tick_period = '0;
    u_if.input_buffer_empty = 1'b1; u_if.token_controller_error = 1'b0;
    u_if.scheduler_error = 1'b0; u_if.packet_out_valid = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk_eq("rst_tick", u_if.tick, 0);
    chk_eq("rst_busy", u_if.busy, 0);
    chk_eq("rst_done", u_if.done, 0);
    chk_eq("rst_error", u_if.error, 0);
    chk_eq("rst_overrun", u_if.overrun, 0);
    chk_eq("rst_step", u_if.step_count, 0);
    reset_n = 1'b1;
    run(3);

    // Basic run: ticks at +11, +21, +31, done at +32
    start_run(3, 10);
    run(40);
    chk_eq("basic_tick0", q_at(tick_log, 0) - t0, 11);
    chk_eq("basic_tick1", q_at(tick_log, 1) - t0, 21);
    chk_eq("basic_tick2", q_at(tick_log, 2) - t0, 31);
    chk_eq("basic_nticks", tick_log.size(), 3);
    chk_eq("basic_done", q_at(done_log, 0) - t0, 32);
    chk_eq("basic_steps", u_if.step_count, 3);
    chk_eq("basic_ovr", u_if.overrun, 0);

    // Buffer stall: empty low in relative cycles 3..9
    start_run(2, 4);
    for (int i = 1; i < 30; i++) begin
      d_empty = !((cyc - t0) >= 3 && (cyc - t0) <= 9);
      step_cycle();
    end
    d_empty = 1'b1;
    chk_eq("stall_tick0", q_at(tick_log, 0) - t0, 11);
    chk_eq("stall_tick1", q_at(tick_log, 1) - t0, 15);
    chk_eq("stall_ovr", u_if.overrun, 1);
    chk_eq("stall_done", q_at(done_log, 0) - t0, 16);

    // Period clamp: period 0 behaves as 2
    start_run(4, 0);
    run(20);
    chk_eq("clamp_tick0", q_at(tick_log, 0) - t0, 3);
    chk_eq("clamp_sp1", q_at(tick_log, 1) - q_at(tick_log, 0), 2);
    chk_eq("clamp_sp3", q_at(tick_log, 3) - q_at(tick_log, 2), 2);
    chk_eq("clamp_nticks", tick_log.size(), 4);

    // Zero steps: done one cycle after start, no tick
    start_run(0, 7);
    run(10);
    chk_eq("zero_done", q_at(done_log, 0) - t0, 1);
    chk_eq("zero_nticks", tick_log.size(), 0);

    // Error during WAIT after step 1, then start ignored, abort recovers
    start_run(5, 4);
    run(6);
    d_se = 1'b1; step_cycle(); d_se = 1'b0;
    run(20);
    d_start = 1'b1; d_num = SW'(3); step_cycle(); d_start = 1'b0;
    run(10);
    chk_eq("err_nticks", tick_log.size(), 1);
    chk_eq("err_flag", u_if.error, 1);
    chk_eq("err_busy", u_if.busy, 0);
    d_abort = 1'b1; step_cycle(); d_abort = 1'b0;
    run(3);
    chk_eq("err_ndone", done_log.size(), 0);

    // Abort in the cycle before tick 2 of 5
    start_run(5, 4);
    run(7);
    d_abort = 1'b1; step_cycle(); d_abort = 1'b0;
    run(10);
    chk_eq("abort_nticks", tick_log.size(), 1);
    chk_eq("abort_ndone", done_log.size(), 0);
    chk_eq("abort_steps", u_if.step_count, 1);
    start_run(5, 4);
    run(30);
    chk_eq("rerun_nticks", tick_log.size(), 5);
    chk_eq("rerun_steps", u_if.step_count, 5);

`ifdef SNN_TICK_SCHED_SPIKE_CNT_EN
    // 7 spikes between ticks 1 and 2 appear the cycle after tick 2
    start_run(3, 10);
    for (int i = 1; i < 22; i++) begin
      d_pov = ((cyc - t0) >= 13 && (cyc - t0) <= 19);
      step_cycle();
    end
    d_pov = 1'b0;
    chk_eq("spike_7", u_if.spike_count, 7);
    run(15);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      d_start = ($urandom_range(0, 5) == 0);
      d_num   = SW'($urandom_range(0, 4));
      d_per   = PW'($urandom_range(0, 6));
      d_empty = ($urandom_range(0, 4) != 0);
      d_se    = ($urandom_range(0, 149) == 0);
      d_tce   = ($urandom_range(0, 149) == 0);
      d_abort = ($urandom_range(0, 119) == 0);
      d_pov   = ($urandom_range(0, 2) == 0);
      step_cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
